// File: rtl/biriscv_mem_pkg.sv
// biriscv_mem_pkg
// Shared types and constants for the biRISC-V memory responder.
//   mem_rsp_t           : one response beat {valid, err, rdata}
//   MEM_MAX_LATENCY     : deepest response pipeline supported
//   MEM_MAX_OUTSTANDING : largest outstanding-request limit supported
//   MEM_LFSR_TAPS       : Fibonacci tap mask for x^16+x^14+x^13+x^11+1
package biriscv_mem_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  localparam int          MEM_MAX_LATENCY     = 4;
  localparam int          MEM_MAX_OUTSTANDING = 4;
  localparam logic [15:0] MEM_LFSR_TAPS       = 16'hB400;

  // Next input bit of the stall LFSR: XOR of the tapped state bits.
  function automatic logic lfsrFeedback(input logic [15:0] state);
    return ^(state & MEM_LFSR_TAPS);
  endfunction

endpackage

// File: rtl/biriscv_mem_rsp_pipe.sv
// biriscv_mem_rsp_pipe
// Fixed-depth delay line for responses; a beat entering at the accepting
// edge leaves LATENCY cycles later. Asynchronous reset empties every stage,
// discarding anything in flight.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   rsp_i  : beat loaded into stage 0 every cycle (valid=0 when idle)
//   rsp_o  : last stage
module biriscv_mem_rsp_pipe
  import biriscv_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_rsp_t rsp_i,
  output mem_rsp_t rsp_o
);

  mem_rsp_t r_stage [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= rsp_i;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign rsp_o = r_stage[LATENCY-1];

endmodule

// File: rtl/biriscv_mem_responder.sv
// biriscv_mem_responder
// Slave end of the biRISC-V req/gnt/rvalid bus: byte-strobed word memory,
// grant limited by an outstanding-request counter, responses returned a
// fixed LATENCY cycles after each accept, strictly in order.
// Optional feature macro: BIRISCV_MEM_RSP_STALL_EN adds an LFSR that
// randomly suppresses about a quarter of grants.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_i, we_i, be_i    : request valid, write enable, byte enables
//   addr_i, wdata_i      : byte address (bits [1:0] ignored), write data
//   gnt_o                : request accepted when req_i & gnt_o
//   rvalid_o, rdata_o, err_o : one-cycle response strobe, data, bus error
module biriscv_mem_responder
  import biriscv_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 20,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_badLatency
    $error("biriscv_mem_responder: LATENCY out of range 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MEM_MAX_OUTSTANDING) begin : g_badOutstanding
    $error("biriscv_mem_responder: MAX_OUTSTANDING out of range 1..4");
  end
  if (LFSR_SEED == 16'h0000) begin : g_badSeed
    $error("biriscv_mem_responder: LFSR_SEED must be nonzero");
  end

  logic [31:0]           r_mem [DEPTH];
  logic [CNT_W-1:0]      r_outCount;
  logic                  w_inRange;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_accept;
  logic                  w_stall;
  logic                  w_room;
  mem_rsp_t              w_rspIn;
  mem_rsp_t              w_rsp;

  assign w_inRange = ((addr_i >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_index   = addr_i[ADDR_WIDTH+1:2];

  // A response leaving this cycle frees its slot immediately, so the grant
  // can rise in the same cycle rvalid_o fires.
  assign w_room   = (r_outCount < CNT_W'(MAX_OUTSTANDING)) | w_rsp.valid;
  assign gnt_o    = rst_ni & w_room & ~w_stall;
  assign w_accept = req_i & gnt_o;

`ifdef BIRISCV_MEM_RSP_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], lfsrFeedback(r_lfsr)};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk_i) begin
    if (w_accept && we_i && w_inRange) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          r_mem[w_index][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's update; a read never
  // coincides with a write, so earlier writes are always visible.
  always_comb begin
    w_rspIn = '0;
    if (w_accept) begin
      w_rspIn.valid = 1'b1;
      if (!w_inRange) begin
        w_rspIn.err = 1'b1;
      end else if (!we_i) begin
        w_rspIn.rdata = r_mem[w_index];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outCount <= '0;
    end else begin
      case ({w_accept, w_rsp.valid})
        2'b10:   r_outCount <= r_outCount + 1'b1;
        2'b01:   r_outCount <= r_outCount - 1'b1;
        default: r_outCount <= r_outCount;
      endcase
    end
  end

  biriscv_mem_rsp_pipe #(
    .LATENCY(LATENCY)
  ) u_rspPipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rsp_i (w_rspIn),
    .rsp_o (w_rsp)
  );

  assign rvalid_o = w_rsp.valid;
  assign rdata_o  = w_rsp.valid ? w_rsp.rdata : 32'd0;
  assign err_o    = w_rsp.valid & w_rsp.err;

endmodule

// File: tb/tb_biriscv_mem_responder.sv
// tb_biriscv_mem_responder
// Directed bench for biriscv_mem_responder built with LATENCY=3,
// MAX_OUTSTANDING=2, ADDR_WIDTH=20 and the stall feature
// (BIRISCV_MEM_RSP_STALL_EN) left undefined.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge (plus 1 time unit for the combinational grant).
module tb_biriscv_mem_responder;

  localparam int LAT  = 3;
  localparam int MAXO = 2;
  localparam int AW   = 20;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk_i = ~clk_i;

  biriscv_mem_responder #(
    .ADDR_WIDTH     (AW),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAXO),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("[TB] %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One request: wait (bounded) for the grant, then wait (bounded) for the
  // response and check its latency, data and error flag.
  task automatic applyStimulus(input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input string tag, input logic [31:0] expRdata,
                               input logic expErr);
    int  waitCycles;
    int  lat;
    bit  got;
    @(negedge clk_i);
    req_i   = 1'b1;
    we_i    = we;
    be_i    = be;
    addr_i  = addr;
    wdata_i = wdata;
    #1;
    waitCycles = 0;
    while (!gnt_o && waitCycles < 20) begin
      @(negedge clk_i);
      #1;
      waitCycles++;
    end
    checkOutput({tag, "_gnt"}, {31'd0, gnt_o}, 32'd1);
    if (!gnt_o) begin
      req_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin
        got = 1'b1;
        lat = i;
        checkOutput({tag, "_rdata"}, rdata_o, expRdata);
        checkOutput({tag, "_err"}, {31'd0, err_o}, {31'd0, expErr});
      end
    end
    checkOutput({tag, "_latency"}, lat, LAT);
  endtask

  initial begin
    logic [31:0] expQ[$];
    logic [31:0] rdAddr [2];
    logic [31:0] rdVal  [2];
    int          accepts;
    int          responses;
    int          strayValid;

    rdAddr[0] = 32'h0000_0100;
    rdAddr[1] = 32'h0000_0200;
    rdVal[0]  = 32'hDEAD_BEEF;
    rdVal[1]  = 32'h11BB_33DD;

    // Reset state
    rst_ni  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = 4'h0;
    addr_i  = 32'd0;
    wdata_i = 32'd0;
    #1;
    checkOutput("reset_gnt", {31'd0, gnt_o}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
    checkOutput("reset_rdata", rdata_o, 32'd0);
    checkOutput("reset_err", {31'd0, err_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("post_reset_gnt", {31'd0, gnt_o}, 32'd1);

    // Basic write/read
    applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "wr100", 32'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 32'h0000_0100, 32'd0, "rd100", 32'hDEAD_BEEF, 1'b0);

    // Byte enables
    applyStimulus(1'b1, 4'hF, 32'h0000_0200, 32'h1122_3344, "wr200_full", 32'd0, 1'b0);
    applyStimulus(1'b1, 4'b0101, 32'h0000_0200, 32'hAABB_CCDD, "wr200_be5", 32'd0, 1'b0);
    applyStimulus(1'b0, 4'hF, 32'h0000_0200, 32'd0, "rd200", 32'h11BB_33DD, 1'b0);

    // Out of range; the write aliases word 0x100 in its low bits
    applyStimulus(1'b0, 4'hF, 32'h0040_0000, 32'd0, "oor_read", 32'd0, 1'b1);
    applyStimulus(1'b1, 4'hF, 32'h0040_0100, 32'h1234_5678, "oor_write", 32'd0, 1'b1);
    applyStimulus(1'b0, 4'hF, 32'h0000_0100, 32'd0, "rd100_after_oor", 32'hDEAD_BEEF, 1'b0);

    // Zero byte-enable write leaves memory alone but still responds
    applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0000_0000, "wr100_be0", 32'd0, 1'b0);
    applyStimulus(1'b0, 4'hF, 32'h0000_0100, 32'd0, "rd100_after_be0", 32'hDEAD_BEEF, 1'b0);

    // Continuous reads: LAT=3 > MAXO=2 gives grant pattern 1,1,0 repeating
    accepts   = 0;
    responses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("stream_rsp%0d", responses), rdata_o, expQ.pop_front());
        end
        responses++;
      end
      req_i  = 1'b1;
      we_i   = 1'b0;
      be_i   = 4'hF;
      addr_i = rdAddr[accepts % 2];
      #1;
      checkOutput($sformatf("stream_gnt%0d", i), {31'd0, gnt_o}, {31'd0, (i % 3) != 2});
      if (gnt_o) begin
        expQ.push_back(rdVal[accepts % 2]);
        accepts++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      if (rvalid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("stream_rsp%0d", responses), rdata_o, expQ.pop_front());
        end
        responses++;
      end
    end
    checkOutput("stream_accepts", accepts, 32'd6);
    checkOutput("stream_responses", responses, accepts);

    // Reset with two requests in flight
    @(negedge clk_i);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0000_0100;
    #1;
    checkOutput("inflight_gnt0", {31'd0, gnt_o}, 32'd1);
    @(negedge clk_i);
    #1;
    checkOutput("inflight_gnt1", {31'd0, gnt_o}, 32'd1);
    @(negedge clk_i);
    req_i  = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_gnt", {31'd0, gnt_o}, 32'd0);
    checkOutput("midreset_rvalid", {31'd0, rvalid_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("after_midreset_gnt", {31'd0, gnt_o}, 32'd1);
    strayValid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (rvalid_o) strayValid++;
    end
    checkOutput("after_midreset_no_rvalid", strayValid, 32'd0);
    applyStimulus(1'b0, 4'hF, 32'h0000_0100, 32'd0, "rd100_after_reset", 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 4'hF, 32'h0000_0200, 32'd0, "rd200_after_reset", 32'h11BB_33DD, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/biriscv_mem_responder.md
# biriscv_mem_responder

Memory-side responder for the biRISC-V core's data/instruction bus (req/gnt/rvalid protocol). It owns a byte-strobed word memory, issues grants subject to an outstanding-request limit, and returns read data/error a fixed, parameterised number of cycles after each accepted request. It is the slave end of the core's `data_*`/`instr_*` ports and serves as the cycle-accurate memory model in fuzzing tops.

## Interface
- `ADDR_WIDTH`, 20: word-address width; memory holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 1: cycles from accept to `rvalid_o`; legal range 1..4.
- `MAX_OUTSTANDING`, 2: max accepted-but-unanswered requests; legal range 1..4.
- `LFSR_SEED`, 16'hACE1: stall-LFSR reset value; must be nonzero.

- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  1  request valid.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables; bit n covers `wdata_i[8n+7:8n]`.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  request accepted this cycle when `req_i & gnt_o`.
- `rvalid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  32  read data, valid with `rvalid_o`.
- `err_o`  out  1  bus error, valid with `rvalid_o`.

## Operation
- accept = `req_i & gnt_o`; `gnt_o` = `rst_ni` & (outstanding < MAX_OUTSTANDING) & !stall; combinational, independent of `req_i`.
- In range: `addr_i[31:ADDR_WIDTH+2] == 0`. Out of range: no memory access, response rdata 0, err 1.
- Write accept: bytes with `be_i[n]=1` updated at the accepting edge; response rdata 0, err 0. `be_i=0` write is legal, memory unchanged, response still issued.
- Read accept: word sampled at the accepting edge (reflects all earlier-accepted writes); `be_i` ignored, full word returned.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)): +1 on accept, -1 on `rvalid_o`, unchanged when both in same cycle; never exceeds MAX_OUTSTANDING nor underflows.
- Response pipeline: LATENCY stages of {valid, err, rdata}; stage 0 loaded on accept, otherwise loaded with valid=0; last stage drives outputs.
- `rdata_o`/`err_o` are 0 whenever `rvalid_o` is 0.
- Responses return strictly in accept order; no back-pressure on responses (initiator must take `rvalid_o`).

## Timing
- Accept at cycle t -> `rvalid_o` high exactly in cycle t+LATENCY, for one cycle.
- Reset values: `rvalid_o`=0, `rdata_o`=0, `err_o`=0, counter 0, pipeline empty, LFSR = LFSR_SEED; `gnt_o`=0 while `rst_ni`=0. Memory contents not reset.
- Reset mid-operation: in-flight responses discarded, no `rvalid_o` after release; writes accepted before reset assertion persist.
- Throughput: one accept per cycle sustained iff MAX_OUTSTANDING >= LATENCY (with stall disabled); otherwise `gnt_o` drops when counter reaches MAX_OUTSTANDING and rises in the cycle `rvalid_o` fires.
- Back-to-back write then read to same word: read returns the written bytes.

## Configuration
- `BIRISCV_MEM_RSP_STALL_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset; stall = (lfsr[1:0] == 2'b00), ≈25% grant suppression for fuzzing back-pressure.
- Undefined: stall tied 0, LFSR not instantiated, `LFSR_SEED` unused.

## Structure
- Package `biriscv_mem_pkg`: `mem_rsp_t` struct {valid, err, rdata[31:0]}, `MEM_MAX_LATENCY`=4, `MEM_MAX_OUTSTANDING`=4, LFSR tap mask constant.
- Sub-module `biriscv_mem_rsp_pipe`: parameterised LATENCY-deep delay line of `mem_rsp_t` with async reset; responder holds memory array, grant logic, counter, LFSR.
- Elaboration-time checks on LATENCY, MAX_OUTSTANDING ranges and LFSR_SEED != 0.

## Test plan
- Write 0xDEADBEEF, be 4'hF, addr 0x100; read 0x100 -> `rvalid_o` at accept+LATENCY, `rdata_o`=0xDEADBEEF, `err_o`=0.
- Full-word 0x11223344 to 0x200, then write 0xAABBCCDD be 4'b0101, read -> 0x11BB33DD.
- Read addr 0x0040_0000 with ADDR_WIDTH=20 -> `rdata_o`=0, `err_o`=1; memory unchanged.
- LATENCY=3, MAX_OUTSTANDING=2, `req_i` held high with reads -> `gnt_o` pattern 1,1,0,1,1,0…; 2 responses per 3 cycles, in order.
- Assert `rst_ni` low one cycle after two accepts -> no `rvalid_o` after release, counter 0, first post-reset `gnt_o`=1.
- With `BIRISCV_MEM_RSP_STALL_EN`, 1000 continuous requests -> every accept answered exactly once in order, grant ratio 0.70–0.80.
